// File: rtl/dot_prod_sequencer.sv
// dot_prod_sequencer: sequences one dotProd kernel run from host beats to result.
// Loads the a/b arrays, fires the kernel, times it, returns result and cycle count.
module dot_prod_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 27,
  parameter int RES_W   = 64,
  parameter int CYC_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     acc_chain,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_a,
  input  logic signed [DATA_W-1:0] s_b,
  input  logic                     s_last,
  output logic                     controlArr,
  output logic                     controlArrWEnable_a,
  output logic                     controlArrWEnable_b,
  output logic [ADDR_W-1:0]        controlArrAddr_a,
  output logic [ADDR_W-1:0]        controlArrAddr_b,
  output logic signed [DATA_W-1:0] controlArrWData_a,
  output logic signed [DATA_W-1:0] controlArrWData_b,
  output logic                     k_r_enable,
  output logic [ADDR_W-1:0]        k_init_i,
  output logic signed [RES_W-1:0]  k_init_acc,
  output logic [ADDR_W:0]          k_len,
  input  logic                     k_w_enable,
  input  logic signed [RES_W-1:0]  k_result,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [RES_W-1:0]  m_result,
  output logic [CYC_W-1:0]         m_cycles,
  output logic                     busy,
  output logic                     err_overflow,
  output logic                     err_timeout
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FLUSH, START, RUN, DONE
  } state_e;

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
  localparam logic [CYC_W-1:0] TMO     = CYC_W'(TIMEOUT);

  state_e                    state_q;
  logic [ADDR_W:0]           cnt_q;
  logic                      we_q;
  logic [ADDR_W-1:0]         addr_q;
  logic signed [DATA_W-1:0]  wda_q;
  logic signed [DATA_W-1:0]  wdb_q;
  logic                      ctrl_q;
  logic                      ren_q;
  logic signed [RES_W-1:0]   acc_q;
  logic [ADDR_W:0]           len_q;
  logic [CYC_W-1:0]          cyc_q;
  logic                      mv_q;
  logic signed [RES_W-1:0]   res_q;
  logic [CYC_W-1:0]          mcyc_q;
  logic signed [RES_W-1:0]   last_q;
  logic                      ovf_q;
  logic                      tmo_q;

  logic                      accept;
  logic                      full;
  logic [CYC_W-1:0]          cyc_d;
  logic signed [RES_W-1:0]   seed_d;

  assign s_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept  = s_valid & s_ready;
  assign full    = (cnt_q == LAST_IDX);
  assign cyc_d   = cyc_q + CYC_ONE;
  assign seed_d  = acc_chain ? last_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wda_q   <= '0;
      wdb_q   <= '0;
      ctrl_q  <= 1'b1;
      ren_q   <= 1'b0;
      acc_q   <= '0;
      len_q   <= '0;
      cyc_q   <= '0;
      mv_q    <= 1'b0;
      res_q   <= '0;
      mcyc_q  <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      ren_q <= 1'b0;
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q[ADDR_W-1:0];
            wda_q  <= s_a;
            wdb_q  <= s_b;
            cnt_q  <= cnt_q + CNT_ONE;
            if (state_q == IDLE) begin
              ovf_q <= 1'b0;
              tmo_q <= 1'b0;
            end
            // A full array forces end of load so no write lands past DEPTH-1.
            if (s_last || full) begin
              state_q <= FLUSH;
              if (!s_last) ovf_q <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        FLUSH: begin
          len_q   <= cnt_q;
          ctrl_q  <= 1'b0;
          ren_q   <= 1'b1;
          state_q <= START;
        end
        START: begin
          acc_q   <= seed_d;
          cyc_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cyc_q <= cyc_d;
          if (k_w_enable) begin
            res_q   <= k_result;
            last_q  <= k_result;
            mcyc_q  <= cyc_d;
            ctrl_q  <= 1'b1;
            mv_q    <= 1'b1;
            state_q <= DONE;
          end else if (cyc_d == TMO) begin
            tmo_q   <= 1'b1;
            res_q   <= '0;
            mcyc_q  <= cyc_d;
            ctrl_q  <= 1'b1;
            mv_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (m_ready) begin
            mv_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign controlArr          = ctrl_q;
  assign controlArrWEnable_a = we_q;
  assign controlArrWEnable_b = we_q;
  assign controlArrAddr_a    = addr_q;
  assign controlArrAddr_b    = addr_q;
  assign controlArrWData_a   = wda_q;
  assign controlArrWData_b   = wdb_q;
  assign k_r_enable          = ren_q;
  assign k_init_i            = '0;
  // Seed follows acc_chain live in START, then stays frozen for the kernel.
  assign k_init_acc          = (state_q == START) ? seed_d : acc_q;
  assign k_len               = len_q;
  assign m_valid             = mv_q;
  assign m_result            = res_q;
  assign m_cycles            = mcyc_q;
  assign busy                = (state_q != IDLE);
  assign err_overflow        = ovf_q;
  assign err_timeout         = tmo_q;

endmodule

// File: tb/tb_dot_prod_sequencer.sv
// tb_dot_prod_sequencer: directed + randomized checks of dot_prod_sequencer
// against a kernel model and a beat-level reference model.
module tb_dot_prod_sequencer;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 27;
  localparam int RES_W  = 64;
  localparam int CYC_W  = 32;
  localparam int TMO    = 20;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic acc_chain = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic signed [DATA_W-1:0] s_a = '0;
  logic signed [DATA_W-1:0] s_b = '0;
  logic s_last = 1'b0;
  logic controlArr;
  logic we_a, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic signed [DATA_W-1:0] wd_a, wd_b;
  logic k_r_enable;
  logic [ADDR_W-1:0] k_init_i;
  logic signed [RES_W-1:0] k_init_acc;
  logic [ADDR_W:0] k_len;
  logic k_w_enable = 1'b0;
  logic signed [RES_W-1:0] k_result = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic signed [RES_W-1:0] m_result;
  logic [CYC_W-1:0] m_cycles;
  logic busy, err_overflow, err_timeout;

  int tests = 0;
  int fails = 0;

  logic signed [DATA_W-1:0] va [DEPTH];
  logic signed [DATA_W-1:0] vb [DEPTH];
  logic signed [DATA_W-1:0] mem_a [DEPTH];
  logic signed [DATA_W-1:0] mem_b [DEPTH];
  longint last_ref = 0;

  dot_prod_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W),
    .CYC_W(CYC_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .acc_chain(acc_chain),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .controlArr(controlArr),
    .controlArrWEnable_a(we_a), .controlArrWEnable_b(we_b),
    .controlArrAddr_a(addr_a), .controlArrAddr_b(addr_b),
    .controlArrWData_a(wd_a), .controlArrWData_b(wd_b),
    .k_r_enable(k_r_enable), .k_init_i(k_init_i),
    .k_init_acc(k_init_acc), .k_len(k_len),
    .k_w_enable(k_w_enable), .k_result(k_result),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_result(m_result), .m_cycles(m_cycles),
    .busy(busy), .err_overflow(err_overflow),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint ref_dot(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
    return s;
  endfunction

  function automatic longint kern_dot(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
    return s;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, controlArr, 1);
    chk({tag, "_we"}, {we_a, we_b}, 0);
    chk({tag, "_addr"}, {addr_a, addr_b}, 0);
    chk({tag, "_wdata"}, {wd_a, wd_b}, 0);
    chk({tag, "_klen"}, k_len, 0);
    chk({tag, "_ren"}, k_r_enable, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_errs"}, {err_overflow, err_timeout}, 0);
    chk({tag, "_mresult"}, m_result, 0);
    chk({tag, "_mcycles"}, m_cycles, 0);
    chk({tag, "_sready"}, s_ready, 1);
  endtask

  task automatic load_vec(input int n, input bit with_last, input bit exp_ovf);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_a = va[i];
      s_b = vb[i];
      s_last = with_last && (i == n - 1);
      chk("s_ready_load", s_ready, 1);
      @(negedge clk);
      chk("wr_ctl", {we_a, we_b, addr_a, addr_b},
          {2'b11, ADDR_W'(i), ADDR_W'(i)});
      chk("wr_data", {wd_a, wd_b}, {va[i], vb[i]});
      if (we_a) begin
        mem_a[addr_a] = wd_a;
        mem_b[addr_b] = wd_b;
      end
      if (i == 0) chk("errs_cleared", {err_overflow, err_timeout}, 0);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("s_ready_after_last", s_ready, 0);
    chk("err_overflow", err_overflow, exp_ovf);
  endtask

  task automatic run_vec(input int n, input bit acc, input longint exp_seed,
                         input int lat, input bit respond, input bit force_en,
                         input longint force_val, input longint exp_res);
    longint ret;
    int waited;
    acc_chain = acc;
    chk("ctrl_flush", controlArr, 1);
    chk("ren_flush", k_r_enable, 0);
    @(negedge clk);
    chk("ren_start", k_r_enable, 1);
    chk("ctrl_start", controlArr, 0);
    chk("k_len", k_len, n);
    chk("k_init_i", k_init_i, 0);
    chk("acc_start", k_init_acc, exp_seed);
    @(negedge clk);
    if (respond) begin
      for (int c = 1; c < lat; c++) begin
        chk("ctrl_run", controlArr, 0);
        chk("ren_run", k_r_enable, 0);
        chk("acc_run", k_init_acc, exp_seed);
        @(negedge clk);
      end
      ret = force_en ? force_val : kern_dot(int'(k_len)) + k_init_acc;
      k_w_enable = 1'b1;
      k_result = ret;
      @(negedge clk);
      k_w_enable = 1'b0;
      k_result = {$urandom, $urandom};
      chk("m_cycles", m_cycles, lat);
      chk("m_result", m_result, exp_res);
    end else begin
      waited = 0;
      while (m_valid !== 1'b1 && waited < 4 * TMO) begin
        @(negedge clk);
        waited++;
      end
      chk("timeout_len", waited, TMO);
      chk("err_timeout", err_timeout, 1);
      chk("m_result_tmo", m_result, 0);
    end
    chk("m_valid_done", m_valid, 1);
    chk("ctrl_done", controlArr, 1);
    chk("s_ready_done", s_ready, 0);
  endtask

  task automatic drain(input int hold, input longint exp_res);
    for (int c = 0; c < hold; c++) begin
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_a = DATA_W'($urandom);
      s_b = DATA_W'($urandom);
      chk("hold_sready", s_ready, 0);
      @(negedge clk);
      chk("hold_we", {we_a, we_b}, 0);
      chk("hold_mvalid", m_valid, 1);
      chk("hold_mresult", m_result, exp_res);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("drain_mvalid", m_valid, 0);
    chk("drain_busy", busy, 0);
    chk("drain_sready", s_ready, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat;
    bit acc;
    longint seed, exp;

    @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    va[0] = DATA_W'(1);  vb[0] = DATA_W'(5);
    va[1] = DATA_W'(-2); vb[1] = DATA_W'(6);
    va[2] = DATA_W'(3);  vb[2] = DATA_W'(-7);
    va[3] = DATA_W'(4);  vb[3] = DATA_W'(8);
    load_vec(4, 1'b1, 1'b0);
    run_vec(4, 1'b0, 0, 9, 1'b1, 1'b1, -16, -16);
    last_ref = -16;
    drain(0, -16);

    load_vec(4, 1'b1, 1'b0);
    run_vec(4, 1'b1, -16, 9, 1'b1, 1'b1, -32, -32);
    last_ref = -32;
    drain(1, -32);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      acc = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 15);
      for (int i = 0; i < n; i++) begin
        va[i] = DATA_W'($urandom);
        vb[i] = DATA_W'($urandom);
      end
      seed = acc ? last_ref : 0;
      exp = ref_dot(n) + seed;
      load_vec(n, 1'b1, 1'b0);
      run_vec(n, acc, seed, lat, 1'b1, 1'b0, 0, exp);
      last_ref = exp;
      drain($urandom_range(0, 3), exp);
    end

    for (int i = 0; i < DEPTH; i++) begin
      va[i] = DATA_W'($urandom);
      vb[i] = DATA_W'($urandom);
    end
    exp = ref_dot(DEPTH);
    load_vec(DEPTH, 1'b0, 1'b1);
    run_vec(DEPTH, 1'b0, 0, 5, 1'b1, 1'b0, 0, exp);
    last_ref = exp;
    drain(1, exp);

    load_vec(3, 1'b1, 1'b0);
    run_vec(3, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    drain(0, 0);

    va[0] = DATA_W'(-7); vb[0] = DATA_W'(11);
    va[1] = DATA_W'(9);  vb[1] = DATA_W'(-3);
    exp = ref_dot(2) + last_ref;
    load_vec(2, 1'b1, 1'b0);
    run_vec(2, 1'b1, last_ref, 7, 1'b1, 1'b0, 0, exp);
    last_ref = exp;
    drain(50, exp);

    load_vec(3, 1'b1, 1'b0);
    acc_chain = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ctrl", controlArr, 0);
    rst = 1'b1;
    #1;
    chk_reset("rst_run");
    @(negedge clk);
    rst = 1'b0;
    last_ref = 0;
    k_w_enable = 1'b1;
    k_result = 64'sd77;
    @(negedge clk);
    k_w_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_mvalid", m_valid, 0);
    chk("stray_busy", busy, 0);
    chk("stray_ctrl", controlArr, 1);
    chk("stray_mresult", m_result, 0);

    va[0] = DATA_W'(12); vb[0] = DATA_W'(-4);
    va[1] = DATA_W'(5);  vb[1] = DATA_W'(6);
    exp = ref_dot(2) + last_ref;
    load_vec(2, 1'b1, 1'b0);
    run_vec(2, 1'b1, last_ref, 3, 1'b1, 1'b0, 0, exp);
    drain(0, exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
